nn_run_sequencer: RTL and testbench

NN_RUN_SEQUENCER -- requirements
Module: nn_run_sequencer

---
 rtl/nn_run_sequencer.sv | 147 ++++++++++++++
 tb/tb_nn_run_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_run_sequencer.sv
// rtl/nn_run_sequencer.sv - layer/argmax run sequencer with watchdog and run-cycle counter
//
// Purpose: steps a classifier run through NUM_LAYERS layer passes on the MAC
// engine, then one argmax pass, and latches the resulting digit.
//
// Ports:
//   Clk, Reset      clock and synchronous active-high reset
//   start, abort    run request (taken only in IDLE) / cancel the current run
//   layer_start     one-cycle pulse to the layer engine; layer_sel = layer index
//   layer_done      layer engine completion pulse
//   max_start       one-cycle pulse to the argmax unit
//   max_done        argmax completion; max_idx valid while it is high
//   digit, valid    latched result and its one-cycle "new digit" pulse
//   busy, error     not-IDLE indicator / sticky watchdog timeout flag
//   run_cycles      cycles spent in the last completed run, saturating
module nn_run_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 65535
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        abort,
  output logic        layer_start,
  output logic [1:0]  layer_sel,
  input  logic        layer_done,
  output logic        max_start,
  input  logic        max_done,
  input  logic [3:0]  max_idx,
  output logic [3:0]  digit,
  output logic        valid,
  output logic        busy,
  output logic        error,
  output logic [15:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAYER_GO,
    S_LAYER_WAIT,
    S_MAX_GO,
    S_MAX_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0]  LAST_LAYER = 2'(NUM_LAYERS - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_layer_sel;
  logic [3:0]  r_digit;
  logic        r_error;
  logic [15:0] r_run_cycles;
  logic [15:0] r_run_cnt;
  logic [15:0] r_wdog;
  logic        w_timeout;
  logic        w_counting;

  // Watchdog value TIMEOUT-1 in a wait state means this is the last cycle
  // a done response can still be accepted.
  assign w_timeout  = (r_wdog == WD_LIMIT);
  assign w_counting = (r_state == S_LAYER_GO) || (r_state == S_LAYER_WAIT) ||
                      (r_state == S_MAX_GO)   || (r_state == S_MAX_WAIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_state_next = S_LAYER_GO;
      S_LAYER_GO:   w_state_next = S_LAYER_WAIT;
      S_LAYER_WAIT: begin
        // A done response in the timeout cycle still wins.
        if (layer_done)
          w_state_next = (r_layer_sel == LAST_LAYER) ? S_MAX_GO : S_LAYER_GO;
        else if (w_timeout)
          w_state_next = S_FAULT;
      end
      S_MAX_GO:     w_state_next = S_MAX_WAIT;
      S_MAX_WAIT: begin
        if (max_done)
          w_state_next = S_DONE;
        else if (w_timeout)
          w_state_next = S_FAULT;
      end
      S_DONE:       w_state_next = S_IDLE;
      S_FAULT:      w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
    // Abort overrides every other transition once a run is under way.
    if (abort && (r_state != S_IDLE))
      w_state_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_layer_sel  <= '0;
      r_digit      <= '0;
      r_error      <= 1'b0;
      r_run_cycles <= '0;
      r_run_cnt    <= '0;
      r_wdog       <= '0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == S_IDLE) && start) begin
        r_layer_sel <= '0;
        r_error     <= 1'b0;
        r_run_cnt   <= '0;
      end else if (w_counting && (r_run_cnt != 16'hFFFF)) begin
        r_run_cnt <= r_run_cnt + 16'd1;
      end

      if ((r_state == S_LAYER_WAIT) && (w_state_next == S_LAYER_GO))
        r_layer_sel <= r_layer_sel + 2'd1;

      // Every wait state is entered from its GO state, so clearing there
      // gives a count of 0 in the first wait cycle.
      if ((r_state == S_LAYER_GO) || (r_state == S_MAX_GO))
        r_wdog <= '0;
      else if ((r_state == S_LAYER_WAIT) || (r_state == S_MAX_WAIT))
        r_wdog <= r_wdog + 16'd1;

      if ((r_state == S_MAX_WAIT) && (w_state_next == S_DONE))
        r_digit <= max_idx;

      if (r_state == S_DONE)
        r_run_cycles <= r_run_cnt;

      // Only a wait state can lead to FAULT, and abort has already
      // redirected w_state_next, so an aborted run never sets error.
      if ((w_state_next == S_FAULT) && (r_state != S_FAULT))
        r_error <= 1'b1;
    end
  end

  assign layer_start = (r_state == S_LAYER_GO);
  assign max_start   = (r_state == S_MAX_GO);
  assign valid       = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign layer_sel   = r_layer_sel;
  assign digit       = r_digit;
  assign error       = r_error;
  assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_nn_run_sequencer.sv
// tb/tb_nn_run_sequencer.sv - self-checking bench for nn_run_sequencer
module tb_nn_run_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, start, abort, layer_done, max_done;
  logic [3:0]  max_idx;

  logic        layer_start, max_start, valid, busy, error;
  logic [1:0]  layer_sel;
  logic [3:0]  digit;
  logic [15:0] run_cycles;

  logic        b_layer_start, b_max_start, b_valid, b_busy, b_error;
  logic [1:0]  b_layer_sel;
  logic [3:0]  b_digit;
  logic [15:0] b_run_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int a_valid_cnt = 0;
  int b_valid_cnt = 0;

  always #5 Clk = ~Clk;

  nn_run_sequencer #(.NUM_LAYERS(3), .TIMEOUT(65535)) u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .layer_start(layer_start), .layer_sel(layer_sel), .layer_done(layer_done),
    .max_start(max_start), .max_done(max_done), .max_idx(max_idx),
    .digit(digit), .valid(valid), .busy(busy), .error(error),
    .run_cycles(run_cycles)
  );

  nn_run_sequencer #(.NUM_LAYERS(3), .TIMEOUT(16)) u_dut_to (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .layer_start(b_layer_start), .layer_sel(b_layer_sel), .layer_done(layer_done),
    .max_start(b_max_start), .max_done(max_done), .max_idx(max_idx),
    .digit(b_digit), .valid(b_valid), .busy(b_busy), .error(b_error),
    .run_cycles(b_run_cycles)
  );

  always @(negedge Clk) begin
    if (valid === 1'b1)   a_valid_cnt++;
    if (b_valid === 1'b1) b_valid_cnt++;
  end

  typedef struct {
    logic        start, abort, ld, md;
    logic [3:0]  idx;
    logic        e_ls;
    logic [1:0]  e_sel;
    logic        e_ms, e_v, e_busy;
    logic [3:0]  e_digit;
    logic [15:0] e_rc;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic st, logic ld, logic md, logic [3:0] idx,
                              logic e_ls, logic [1:0] e_sel, logic e_ms,
                              logic e_v, logic e_busy, logic [3:0] e_digit,
                              logic [15:0] e_rc);
    vec_t v;
    v.start = st; v.abort = 1'b0; v.ld = ld; v.md = md; v.idx = idx;
    v.e_ls = e_ls; v.e_sel = e_sel; v.e_ms = e_ms; v.e_v = e_v;
    v.e_busy = e_busy; v.e_digit = e_digit; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ls"},    {31'd0, layer_start}, 0);
    chk({tag, "_ms"},    {31'd0, max_start}, 0);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
    chk({tag, "_sel"},   {30'd0, layer_sel}, 0);
    chk({tag, "_digit"}, {28'd0, digit}, 0);
    chk({tag, "_rc"},    {16'd0, run_cycles}, 0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; abort = vecs[i].abort;
      layer_done = vecs[i].ld; max_done = vecs[i].md; max_idx = vecs[i].idx;
      step();
      start = 1'b0; abort = 1'b0; layer_done = 1'b0; max_done = 1'b0;
      chk($sformatf("%s[%0d]_ls", tag, i),    {31'd0, layer_start}, {31'd0, vecs[i].e_ls});
      chk($sformatf("%s[%0d]_ms", tag, i),    {31'd0, max_start},   {31'd0, vecs[i].e_ms});
      chk($sformatf("%s[%0d]_valid", tag, i), {31'd0, valid},       {31'd0, vecs[i].e_v});
      chk($sformatf("%s[%0d]_busy", tag, i),  {31'd0, busy},        {31'd0, vecs[i].e_busy});
      chk($sformatf("%s[%0d]_digit", tag, i), {28'd0, digit},       {28'd0, vecs[i].e_digit});
      chk($sformatf("%s[%0d]_rc", tag, i),    {16'd0, run_cycles},  {16'd0, vecs[i].e_rc});
      if (vecs[i].e_busy)
        chk($sformatf("%s[%0d]_sel", tag, i), {30'd0, layer_sel}, {30'd0, vecs[i].e_sel});
    end
  endtask

  // Start a run with immediate layer responses and stop in MAX_WAIT.
  task automatic run_to_max_wait;
    start = 1'b1; step(); start = 1'b0;
    for (int l = 0; l < 3; l++) begin
      step();
      layer_done = 1'b1; step(); layer_done = 1'b0;
    end
    step();
  endtask

  initial begin
    int v0;
    Reset = 1'b1; start = 1'b0; abort = 1'b0;
    layer_done = 1'b0; max_done = 1'b0; max_idx = 4'd0;

    //            st  ld  md  idx  ls sel ms v  busy dig rc
    vecs[0]  = mk(0,  1,  1,  5,   0, 0,  0, 0, 0,   0,  0);  // spurious in IDLE
    vecs[1]  = mk(1,  0,  0,  0,   1, 0,  0, 0, 1,   0,  0);
    vecs[2]  = mk(0,  1,  1,  6,   0, 0,  0, 0, 1,   0,  0);  // spurious in LAYER_GO
    vecs[3]  = mk(0,  1,  0,  0,   1, 1,  0, 0, 1,   0,  0);
    vecs[4]  = mk(0,  0,  0,  0,   0, 1,  0, 0, 1,   0,  0);
    vecs[5]  = mk(0,  1,  0,  0,   1, 2,  0, 0, 1,   0,  0);
    vecs[6]  = mk(0,  0,  0,  0,   0, 2,  0, 0, 1,   0,  0);
    vecs[7]  = mk(0,  1,  0,  0,   0, 2,  1, 0, 1,   0,  0);
    vecs[8]  = mk(0,  1,  1,  4,   0, 2,  0, 0, 1,   0,  0);  // spurious in MAX_GO
    vecs[9]  = mk(0,  0,  1,  7,   0, 2,  0, 1, 1,   7,  0);
    vecs[10] = mk(0,  0,  0,  0,   0, 2,  0, 0, 0,   7,  8);
    vecs[11] = mk(0,  1,  1,  2,   0, 2,  0, 0, 0,   7,  8);  // spurious in IDLE

    step(); step();
    Reset = 1'b0;
    chk_reset_vals("reset");

    // Nominal run, with spurious responses inside the table.
    run_table("nom");

    // Slow engine: 100 wait cycles per layer, 2 in MAX_WAIT, a second start mid-run.
    v0 = a_valid_cnt;
    start = 1'b1; step(); start = 1'b0;
    chk("slow_ls0", {31'd0, layer_start}, 1);
    for (int l = 0; l < 3; l++) begin
      step();
      for (int c = 0; c < 99; c++) begin
        start = (l == 1 && c == 50);
        step();
      end
      start = 1'b0;
      layer_done = 1'b1; step(); layer_done = 1'b0;
      if (l < 2) begin
        chk($sformatf("slow_ls%0d", l + 1), {31'd0, layer_start}, 1);
        chk($sformatf("slow_sel%0d", l + 1), {30'd0, layer_sel}, l + 1);
      end else begin
        chk("slow_ms", {31'd0, max_start}, 1);
      end
    end
    step(); step();
    max_done = 1'b1; max_idx = 4'd3; step(); max_done = 1'b0;
    chk("slow_valid", {31'd0, valid}, 1);
    chk("slow_digit", {28'd0, digit}, 3);
    step();
    chk("slow_rc", {16'd0, run_cycles}, 306);
    chk("slow_idle", {31'd0, busy}, 0);
    repeat (3) step();
    chk("slow_one_valid", a_valid_cnt - v0, 1);
    chk("slow_busy_after", {31'd0, busy}, 0);

    // Abort in the same cycle as max_done.
    v0 = a_valid_cnt;
    run_to_max_wait();
    max_done = 1'b1; max_idx = 4'd9; abort = 1'b1; step();
    max_done = 1'b0; abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_digit", {28'd0, digit}, 3);
    chk("abort_rc", {16'd0, run_cycles}, 306);
    chk("abort_error", {31'd0, error}, 0);
    step();
    chk("abort_no_valid", a_valid_cnt - v0, 0);

    // Abort in IDLE alongside start: start is accepted.
    abort = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("abort_idle_ls", {31'd0, layer_start}, 1);
    chk("abort_idle_busy", {31'd0, busy}, 1);
    step(); abort = 1'b0;
    chk("abort_go_busy", {31'd0, busy}, 0);

    // Reset mid-run in LAYER_WAIT with layer_sel=1, then a fresh run.
    start = 1'b1; step(); start = 1'b0;
    step();
    layer_done = 1'b1; step(); layer_done = 1'b0;
    step();
    chk("rmid_sel", {30'd0, layer_sel}, 1);
    chk("rmid_busy", {31'd0, busy}, 1);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk_reset_vals("rmid");
    step();
    chk("rmid_no_ls", {31'd0, layer_start}, 0);
    chk("rmid_no_busy", {31'd0, busy}, 0);
    run_table("fresh");

    // Watchdog on the TIMEOUT=16 instance.
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    v0 = b_valid_cnt;
    start = 1'b1; step(); start = 1'b0;
    step();
    repeat (15) step();
    chk("to_wait_busy", {31'd0, b_busy}, 1);
    chk("to_wait_err", {31'd0, b_error}, 0);
    step();
    chk("to_fault_err", {31'd0, b_error}, 1);
    chk("to_fault_busy", {31'd0, b_busy}, 1);
    step();
    chk("to_idle_busy", {31'd0, b_busy}, 0);
    chk("to_idle_err", {31'd0, b_error}, 1);
    chk("to_digit", {28'd0, b_digit}, 0);
    chk("to_rc", {16'd0, b_run_cycles}, 0);
    step();
    chk("to_sticky", {31'd0, b_error}, 1);
    chk("to_no_valid", b_valid_cnt - v0, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("to_clear_err", {31'd0, b_error}, 0);
    chk("to_restart_ls", {31'd0, b_layer_start}, 1);
    // Done arriving in the timeout cycle wins.
    step();
    repeat (15) step();
    layer_done = 1'b1; step(); layer_done = 1'b0;
    chk("to_race_ls", {31'd0, b_layer_start}, 1);
    chk("to_race_sel", {30'd0, b_layer_sel}, 1);
    chk("to_race_err", {31'd0, b_error}, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("to_abort_busy", {31'd0, b_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
